// File: rtl/ramen_ledger_pkg.sv
// Shared constants, report word layout and FSM state type for the Ramen daily ledger.
package ramen_ledger_pkg;

   localparam int SOLD_FIELD_W = 7;
   localparam int NUM_TYPES    = 4;

   localparam logic [2:0] W_DAY   = 3'd0;
   localparam logic [2:0] W_OK    = 3'd1;
   localparam logic [2:0] W_FAIL  = 3'd2;
   localparam logic [2:0] W_GAIN  = 3'd3;
   localparam logic [2:0] W_SOLD0 = 3'd4;
   localparam logic [2:0] W_LAST  = 3'd7;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CLOSE   = 2'd1,
      REPORT  = 2'd2
   } ledger_state_e;

   // Sum of the four 7-bit sold fields; 9 bits hold the worst case of 4*127.
   function automatic logic [8:0] sold_sum(
      input logic [NUM_TYPES-1:0][SOLD_FIELD_W-1:0] sold
   );
      logic [8:0] acc;
      acc = 9'd0;
      for (int i = 0; i < NUM_TYPES; i++) begin
         acc = acc + {2'b00, sold[i]};
      end
      return acc;
   endfunction

endpackage

// File: rtl/ramen_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ramen_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

   logic [W-1:0] count_r;

   // Counter register: reset, clear, then saturating increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {W{1'b0}};
      end else if (clr) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != MAX_VAL)) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/ramen_daily_ledger.sv
// Daily ledger for the Ramen shop: per-day order stats, cumulative gain and an
// 8-word report streamed over valid/ready.
module ramen_daily_ledger
   import ramen_ledger_pkg::*;
#(
   parameter int DAY_W = 8,
   parameter int CNT_W = 8,
   parameter int CUM_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ord_valid,
   input  logic             ord_success,
   input  logic             tot_valid,
   input  logic [14:0]      tot_gain,
   input  logic [27:0]      tot_sold,
   input  logic             rpt_ready,
   output logic             rpt_valid,
   output logic [15:0]      rpt_data,
   output logic             rpt_last,
   output logic [CUM_W-1:0] cum_gain,
   output logic [DAY_W-1:0] day_cnt,
   output logic             err_mismatch,
   output logic             err_overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CUM_W-1:0] CUM_MAX = {CUM_W{1'b1}};

   ledger_state_e state_r, state_nx_s;
   logic [2:0]    idx_r, idx_nx_s;

   logic [CNT_W-1:0] ok_cnt_s, fail_cnt_s;
   logic [DAY_W-1:0] day_cnt_s;
   logic             ok_inc_s, fail_inc_s, close_s, hs_s, done_s;
   logic [CNT_W-1:0] ok_snap_nx_s, fail_snap_nx_s;

   logic [CNT_W-1:0] snap_ok_r, snap_fail_r;
   logic [14:0]      snap_gain_r;
   logic [NUM_TYPES-1:0][SOLD_FIELD_W-1:0] snap_sold_r;

   logic [CUM_W:0]   cum_sum_s;
   logic             mismatch_s;
   logic [15:0]      word_s;

   logic             rpt_valid_r, rpt_last_r, err_mismatch_r, err_overrun_r;
   logic [15:0]      rpt_data_r;
   logic [CUM_W-1:0] cum_r;

   assign ok_inc_s   = ord_valid & ord_success;
   assign fail_inc_s = ord_valid & ~ord_success;
   assign close_s    = tot_valid && (state_r == COLLECT);
   assign hs_s       = rpt_valid_r & rpt_ready;
   assign done_s     = hs_s && (state_r == REPORT) && (idx_r == W_LAST);

   ramen_sat_counter #(.W(CNT_W)) u_ok_cnt (
      .clk(clk), .rst(rst), .clr(close_s), .inc(ok_inc_s), .count(ok_cnt_s)
   );

   ramen_sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk(clk), .rst(rst), .clr(close_s), .inc(fail_inc_s), .count(fail_cnt_s)
   );

   ramen_sat_counter #(.W(DAY_W)) u_day_cnt (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(done_s), .count(day_cnt_s)
   );

   // An order arriving in the closing cycle belongs to the closing day.
   assign ok_snap_nx_s   = (ok_inc_s && (ok_cnt_s != CNT_MAX))
                           ? ok_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1} : ok_cnt_s;
   assign fail_snap_nx_s = (fail_inc_s && (fail_cnt_s != CNT_MAX))
                           ? fail_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1} : fail_cnt_s;

   assign cum_sum_s  = {1'b0, cum_r} + (CUM_W+1)'(snap_gain_r);
   assign mismatch_s = (16'(sold_sum(snap_sold_r)) != 16'(snap_ok_r));

   // Next-state and report word index.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      case (state_r)
         COLLECT: begin
            if (tot_valid) begin
               state_nx_s = CLOSE;
            end else begin
               state_nx_s = COLLECT;
            end
         end
         CLOSE: begin
            state_nx_s = REPORT;
            idx_nx_s   = W_DAY;
         end
         REPORT: begin
            if (hs_s && (idx_r == W_LAST)) begin
               state_nx_s = COLLECT;
               idx_nx_s   = W_DAY;
            end else if (hs_s) begin
               idx_nx_s   = idx_r + 3'd1;
            end else begin
               idx_nx_s   = idx_r;
            end
         end
         default: begin
            state_nx_s = COLLECT;
            idx_nx_s   = W_DAY;
         end
      endcase
   end

   // Report word selected by the upcoming index so the data register lines up with valid.
   always_comb begin
      word_s = 16'd0;
      case (idx_nx_s)
         W_DAY:   word_s = 16'(day_cnt_s);
         W_OK:    word_s = 16'(snap_ok_r);
         W_FAIL:  word_s = 16'(snap_fail_r);
         W_GAIN:  word_s = 16'(snap_gain_r);
         default: word_s = 16'(snap_sold_r[2'(idx_nx_s - W_SOLD0)]);
      endcase
   end

   // State, snapshot, accumulator, sticky flags and registered report outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= COLLECT;
         idx_r          <= 3'd0;
         snap_ok_r      <= {CNT_W{1'b0}};
         snap_fail_r    <= {CNT_W{1'b0}};
         snap_gain_r    <= 15'd0;
         snap_sold_r    <= 28'd0;
         cum_r          <= {CUM_W{1'b0}};
         err_mismatch_r <= 1'b0;
         err_overrun_r  <= 1'b0;
         rpt_valid_r    <= 1'b0;
         rpt_data_r     <= 16'd0;
         rpt_last_r     <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         idx_r   <= idx_nx_s;
         if (close_s) begin
            snap_ok_r   <= ok_snap_nx_s;
            snap_fail_r <= fail_snap_nx_s;
            snap_gain_r <= tot_gain;
            snap_sold_r <= tot_sold;
         end
         if (state_r == CLOSE) begin
            cum_r <= cum_sum_s[CUM_W] ? CUM_MAX : cum_sum_s[CUM_W-1:0];
            if (mismatch_s) begin
               err_mismatch_r <= 1'b1;
            end
         end
         if (tot_valid && (state_r != COLLECT)) begin
            err_overrun_r <= 1'b1;
         end
         rpt_valid_r <= (state_nx_s == REPORT);
         rpt_data_r  <= (state_nx_s == REPORT) ? word_s : 16'd0;
         rpt_last_r  <= (state_nx_s == REPORT) && (idx_nx_s == W_LAST);
      end
   end

   assign rpt_valid    = rpt_valid_r;
   assign rpt_data     = rpt_data_r;
   assign rpt_last     = rpt_last_r;
   assign cum_gain     = cum_r;
   assign day_cnt      = day_cnt_s;
   assign err_mismatch = err_mismatch_r;
   assign err_overrun  = err_overrun_r;

endmodule

// File: tb/tb_ramen_daily_ledger.sv
// Scoreboard bench for ramen_daily_ledger: a day-level reference model queues the
// expected report words, a negedge monitor pops and compares them.
module tb_ramen_daily_ledger;

   logic        clk = 1'b0;
   logic        rst, ord_valid, ord_success, tot_valid, rpt_ready;
   logic [14:0] tot_gain;
   logic [27:0] tot_sold;
   logic        rpt_valid, rpt_last, err_mismatch, err_overrun;
   logic [15:0] rpt_data;
   logic [19:0] cum_gain;
   logic [7:0]  day_cnt;

   always #5 clk = ~clk;

   ramen_daily_ledger #(.DAY_W(8), .CNT_W(8), .CUM_W(20)) dut (
      .clk(clk), .rst(rst), .ord_valid(ord_valid), .ord_success(ord_success),
      .tot_valid(tot_valid), .tot_gain(tot_gain), .tot_sold(tot_sold),
      .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_data(rpt_data),
      .rpt_last(rpt_last), .cum_gain(cum_gain), .day_cnt(day_cnt),
      .err_mismatch(err_mismatch), .err_overrun(err_overrun)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: open-day tallies, pending report progress, totals.
   int m_ok, m_fail, m_left, m_gap, m_day, m_cum, m_pgain;
   bit m_pmis, m_mis, m_ovr, armed;
   logic [16:0] sb[$];

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [27:0] pack_sold(int a, int b, int c, int d);
      logic [6:0] fa, fb, fc, fd;
      fa = 7'(a); fb = 7'(b); fc = 7'(c); fd = 7'(d);
      return {fd, fc, fb, fa};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: advances once per rising edge from the same inputs the DUT samples.
   initial begin
      armed = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_ok = 0; m_fail = 0; m_left = 0; m_gap = 0; m_day = 0; m_cum = 0;
            m_pgain = 0; m_pmis = 1'b0; m_mis = 1'b0; m_ovr = 1'b0;
            sb.delete();
         end else begin
            int inc_ok, inc_fail, so, sf, sum;
            bit acc;
            inc_ok   = (ord_valid && ord_success) ? 1 : 0;
            inc_fail = (ord_valid && !ord_success) ? 1 : 0;
            acc      = tot_valid && (m_left == 0);
            if (m_left > 0) begin
               if (m_gap > 0) begin
                  m_gap = 0;
                  m_cum = sat(m_cum + m_pgain, 1048575);
                  if (m_pmis) m_mis = 1'b1;
               end else if (rpt_ready) begin
                  m_left--;
                  if (m_left == 0) m_day = sat(m_day + 1, 255);
               end
            end
            if (acc) begin
               so = sat(m_ok + inc_ok, 255);
               sf = sat(m_fail + inc_fail, 255);
               sb.push_back({1'b0, 16'(m_day)});
               sb.push_back({1'b0, 16'(so)});
               sb.push_back({1'b0, 16'(sf)});
               sb.push_back({1'b0, 16'(tot_gain)});
               sum = 0;
               for (int k = 0; k < 4; k++) begin
                  int f;
                  f = int'((tot_sold >> (7 * k)) & 28'h7F);
                  sum += f;
                  sb.push_back({(k == 3), 16'(f)});
               end
               m_ok = 0; m_fail = 0; m_left = 8; m_gap = 1;
               m_pgain = int'(tot_gain);
               m_pmis  = (sum != so);
            end else begin
               m_ok   = sat(m_ok + inc_ok, 255);
               m_fail = sat(m_fail + inc_fail, 255);
               if (tot_valid) m_ovr = 1'b1;
            end
         end
         armed = 1'b1;
      end
   end

   // Monitor: compares outputs at the falling edge, pops a word per handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            bit exp_valid;
            exp_valid = (m_left > 0) && (m_gap == 0);
            chk("rpt_valid", rpt_valid, exp_valid);
            if (rpt_valid && exp_valid) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_empty actual=word required=none t=%0t", $time);
               end else begin
                  chk("rpt_data", rpt_data, sb[0][15:0]);
                  chk("rpt_last", rpt_last, sb[0][16]);
                  if (rpt_ready) void'(sb.pop_front());
               end
            end
            chk("cum_gain", cum_gain, m_cum);
            chk("day_cnt", day_cnt, m_day);
            chk("err_mismatch", err_mismatch, m_mis);
            chk("err_overrun", err_overrun, m_ovr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      ord_valid = 1'b0;
      tot_valid = 1'b0;
   endtask

   task automatic order(input bit s);
      ord_valid = 1'b1; ord_success = s;
      tick();
   endtask

   task automatic close_day(input int gain, input logic [27:0] sold, input bit with_ord);
      tot_valid = 1'b1; tot_gain = 15'(gain); tot_sold = sold;
      ord_valid = with_ord; ord_success = 1'b1;
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && m_left != 0; i++) tick();
      checks++;
      if (m_left != 0) begin
         errors++;
         $display("FAIL report_timeout actual=%0d required=0", m_left);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         ord_valid = 1'($urandom); ord_success = 1'($urandom);
         tot_valid = 1'($urandom); tot_gain = 15'($urandom);
         tot_sold = 28'($urandom); rpt_ready = 1'($urandom);
         tick();
      end
      chk("reset_data", rpt_data, 0);
      chk("reset_last", rpt_last, 0);
      rst = 1'b0; rpt_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; ord_valid = 1'b0; ord_success = 1'b0; tot_valid = 1'b0;
      tot_gain = 15'd0; tot_sold = 28'd0; rpt_ready = 1'b1;

      // Reset with random inputs, then close immediately after release.
      do_reset(3);
      close_day(77, pack_sold(0, 0, 0, 0), 1'b0);
      wait_idle();

      // Normal day: 3 successes, 2 failures.
      do_reset(2);
      order(1); order(0); order(1); order(0); order(1);
      close_day(1200, pack_sold(1, 1, 1, 0), 1'b0);
      wait_idle();

      // Same day again with a 4-cycle stall while word 3 is presented.
      order(1); order(0); order(1); order(0); order(1);
      close_day(1200, pack_sold(1, 1, 1, 0), 1'b0);
      for (int i = 0; i < 50 && !(m_left == 5 && m_gap == 0); i++) tick();
      rpt_ready = 1'b0;
      repeat (4) tick();
      rpt_ready = 1'b1;
      wait_idle();

      // Order and close in the same cycle, sold count disagrees.
      do_reset(2);
      order(1); order(1);
      close_day(300, pack_sold(1, 0, 0, 0), 1'b1);
      wait_idle();
      close_day(5, pack_sold(0, 0, 0, 0), 1'b0);
      wait_idle();

      // Overrun: second close while the first report is stalled.
      do_reset(2);
      order(1); order(1);
      rpt_ready = 1'b0;
      close_day(500, pack_sold(2, 0, 0, 0), 1'b0);
      repeat (3) tick();
      close_day(700, pack_sold(0, 0, 0, 0), 1'b0);
      order(1);
      repeat (2) tick();
      rpt_ready = 1'b1;
      wait_idle();
      close_day(1, pack_sold(1, 0, 0, 0), 1'b0);
      wait_idle();

      // Randomized traffic with random backpressure.
      do_reset(2);
      for (int i = 0; i < 2000; i++) begin
         ord_valid   = ($urandom_range(0, 2) == 0);
         ord_success = 1'($urandom);
         tot_valid   = ($urandom_range(0, 59) == 0);
         tot_gain    = 15'($urandom);
         tot_sold    = pack_sold($urandom_range(0, 3), $urandom_range(0, 3),
                                 $urandom_range(0, 3), $urandom_range(0, 3));
         rpt_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      rpt_ready = 1'b1;
      wait_idle();

      // Saturation of per-day counter and cumulative gain.
      do_reset(2);
      for (int d = 0; d < 40; d++) begin
         for (int k = 0; k < 300; k++) order(1);
         close_day(32767, pack_sold(127, 127, 1, 0), 1'b0);
         wait_idle();
      end
      chk("cum_pinned", cum_gain, 1048575);

      repeat (3) tick();
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
